ripple_count_capture: RTL and testbench

Downstream consumer of the 8-bit asynchronous ripple counter. It brings the counter's free-running, skew-prone output into the system clock domain. On a snapshot request it waits until the synchronized value is stable, then captures it and computes the modulo-2^WIDTH delta since the previous good capture. Results go out through a valid/ready handshake to the system-side logic (rate meter, event logger).

---
 rtl/ripple_count_capture.sv | 138 +++++++++++++
 tb/tb_ripple_count_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// Brings a free-running asynchronous ripple counter into clk, captures it once stable and reports the delta.
// Optional RCC_GLITCH_CNT_EN adds a saturating count of unstable samples seen while settling.
//
// state  | meaning
// IDLE   | waiting for a snapshot request
// SETTLE | waiting for STABLE_CYCLES equal synchronized samples, or TIMEOUT
// HOLD   | result presented on out_*, waiting for out_ready
module ripple_count_capture #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             snap,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             out_wrap,
  output logic             out_err,
  output logic             busy,
  output logic             drop
`ifdef RCC_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_sample;
  logic [WIDTH-1:0] last_good;
  logic [SW-1:0]    stable_cnt;
  logic [TW-1:0]    to_cnt;
  logic [WIDTH-1:0] sync_out;
  logic             match;
  logic             stable_done;
  logic             to_done;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign match       = (sync_out == prev_sample);
  // Both fire on the edge where the counter would reach its terminal value.
  assign stable_done = match && (stable_cnt == SW'(STABLE_CYCLES - 2));
  assign to_done     = (to_cnt == TW'(TIMEOUT - 2));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_sample <= '0;
    end else begin
      sync_q[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_sample <= sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_good  <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_delta  <= '0;
      out_wrap   <= 1'b0;
      out_err    <= 1'b0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (snap) begin
            state      <= S_SETTLE;
            stable_cnt <= '0;
            to_cnt     <= '0;
          end
        end
        S_SETTLE: begin
          if (snap) drop <= 1'b1;
          stable_cnt <= match ? stable_cnt + SW'(1) : '0;
          to_cnt     <= to_cnt + TW'(1);
          if (stable_done) begin
            out_count <= sync_out;
            out_delta <= sync_out - last_good;
            out_wrap  <= (sync_out < last_good);
            out_err   <= 1'b0;
            last_good <= sync_out;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (to_done) begin
            // Unverified value: reported, but never used as a delta reference.
            out_count <= sync_out;
            out_delta <= '0;
            out_wrap  <= 1'b0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (snap) begin
              state      <= S_SETTLE;
              stable_cnt <= '0;
              to_cnt     <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else if (snap) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RCC_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      glitch_cnt <= 8'd0;
    else if (state == S_SETTLE && !match && glitch_cnt != 8'hFF)
      glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture: per-cycle vector table plus hand sequences
// for settling, timeout and reset corner cases.
module tb_ripple_count_capture;
  localparam int W  = 8;
  localparam int TO = 64;
  localparam bit O  = 1'b0;
  localparam bit I  = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         snap;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_count;
  logic [W-1:0] out_delta;
  logic         out_wrap;
  logic         out_err;
  logic         busy;
  logic         drop;
`ifdef RCC_GLITCH_CNT_EN
  logic [7:0]   glitch_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ripple_count_capture #(.WIDTH(W), .SYNC_STAGES(2), .STABLE_CYCLES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .snap(snap), .out_ready(out_ready),
    .out_valid(out_valid), .out_count(out_count), .out_delta(out_delta),
    .out_wrap(out_wrap), .out_err(out_err), .busy(busy), .drop(drop)
`ifdef RCC_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         snp;
    logic         rdy;
    logic         v;
    logic [W-1:0] count;
    logic [W-1:0] delta;
    logic         wrap;
    logic         err;
    logic         bsy;
    logic         drp;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [W-1:0] c, input logic s, input logic r, input logic v,
                              input logic [W-1:0] oc, input logic [W-1:0] od,
                              input logic w, input logic e, input logic b, input logic d);
    vec_t t;
    t.cnt = c; t.snp = s; t.rdy = r; t.v = v; t.count = oc; t.delta = od;
    t.wrap = w; t.err = e; t.bsy = b; t.drp = d;
    return t;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_valid"}, out_valid, 1'b0);
    chk8({nm, "_count"}, out_count, 8'h00);
    chk8({nm, "_delta"}, out_delta, 8'h00);
    chk1({nm, "_wrap"},  out_wrap,  1'b0);
    chk1({nm, "_err"},   out_err,   1'b0);
    chk1({nm, "_busy"},  busy,      1'b0);
    chk1({nm, "_drop"},  drop,      1'b0);
  endtask

  int n;

  initial begin
    rst = 1'b0; cnt_in = 8'h00; snap = 1'b0; out_ready = 1'b0;

    //              cnt    snp rdy v  count  delta  wr er bsy drp
    tbl[0]  = mk(8'h25, O, O, O, 8'h00, 8'h00, O, O, O, O);
    tbl[1]  = mk(8'h25, O, O, O, 8'h00, 8'h00, O, O, O, O);
    tbl[2]  = mk(8'h25, O, O, O, 8'h00, 8'h00, O, O, O, O);
    tbl[3]  = mk(8'h25, O, O, O, 8'h00, 8'h00, O, O, O, O);
    tbl[4]  = mk(8'h25, I, O, O, 8'h00, 8'h00, O, O, I, O);
    tbl[5]  = mk(8'h25, O, O, I, 8'h25, 8'h25, O, O, I, O);
    tbl[6]  = mk(8'h25, O, O, I, 8'h25, 8'h25, O, O, I, O);
    tbl[7]  = mk(8'h25, O, I, O, 8'h25, 8'h25, O, O, O, O);
    tbl[8]  = mk(8'h10, O, O, O, 8'h25, 8'h25, O, O, O, O);
    tbl[9]  = mk(8'h10, O, O, O, 8'h25, 8'h25, O, O, O, O);
    tbl[10] = mk(8'h10, O, O, O, 8'h25, 8'h25, O, O, O, O);
    tbl[11] = mk(8'h10, O, O, O, 8'h25, 8'h25, O, O, O, O);
    tbl[12] = mk(8'h10, I, O, O, 8'h25, 8'h25, O, O, I, O);
    tbl[13] = mk(8'h10, O, O, I, 8'h10, 8'hEB, I, O, I, O);
    tbl[14] = mk(8'h10, I, O, I, 8'h10, 8'hEB, I, O, I, I);
    tbl[15] = mk(8'h10, O, O, I, 8'h10, 8'hEB, I, O, I, O);
    tbl[16] = mk(8'h10, I, I, O, 8'h10, 8'hEB, I, O, I, O);
    tbl[17] = mk(8'h10, O, O, I, 8'h10, 8'h00, O, O, I, O);
    tbl[18] = mk(8'h10, O, I, O, 8'h10, 8'h00, O, O, O, O);

    #12;
    chk_all_zero("reset");
    rst = 1'b1;

    // Mid-run reset while a result is held.
    cnt_in = 8'hAA;
    repeat (4) tick;
    snap = 1'b1; tick; snap = 1'b0; tick;
    chk1("t1_valid_pre", out_valid, 1'b1);
    chk8("t1_count_pre", out_count, 8'hAA);
    #2 rst = 1'b0; #1;
    chk_all_zero("t1_async_rst");
    tick; rst = 1'b1; tick;
    chk1("t1_busy_post", busy, 1'b0);

    for (int k = 0; k < 19; k++) begin
      cnt_in = tbl[k].cnt; snap = tbl[k].snp; out_ready = tbl[k].rdy;
      tick;
      chk1($sformatf("v%0d_valid", k), out_valid, tbl[k].v);
      chk8($sformatf("v%0d_count", k), out_count, tbl[k].count);
      chk8($sformatf("v%0d_delta", k), out_delta, tbl[k].delta);
      chk1($sformatf("v%0d_wrap", k),  out_wrap,  tbl[k].wrap);
      chk1($sformatf("v%0d_err", k),   out_err,   tbl[k].err);
      chk1($sformatf("v%0d_busy", k),  busy,      tbl[k].bsy);
      chk1($sformatf("v%0d_drop", k),  drop,      tbl[k].drp);
    end
    snap = 1'b0; out_ready = 1'b0;

    // Toggling 0x0F/0x10; snap one cycle in so the toggles have reached the synchronizer.
    for (int i = 0; i < 12; i++) begin
      cnt_in = (i < 10 && i % 2 == 0) ? 8'h0F : 8'h10;
      snap   = (i == 1 || i == 5);
      tick;
      chk1($sformatf("t4_novalid_%0d", i), out_valid, 1'b0);
      if (i == 1) chk1("t4_busy", busy, 1'b1);
      if (i == 5) chk1("t4_drop_settle", drop, 1'b1);
    end
    snap = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    chk1("t4_valid", out_valid, 1'b1);
    chki("t4_latency", n, 1);
    chk8("t4_count", out_count, 8'h10);
    chk8("t4_delta", out_delta, 8'h00);
    chk1("t4_err", out_err, 1'b0);
`ifdef RCC_GLITCH_CNT_EN
    chk1("t4_glitch_ge9", glitch_cnt >= 8'd9, 1'b1);
`endif
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk1("t4_ack", out_valid, 1'b0);

    // Continuous toggling forces the timeout path.
    for (int i = 0; i < 2; i++) begin
      cnt_in = (i % 2 == 0) ? 8'hAA : 8'h55;
      snap   = (i == 1);
      tick;
    end
    snap = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      cnt_in = (n % 2 == 0) ? 8'hAA : 8'h55;
      tick;
      n++;
    end
    chk1("t5_valid", out_valid, 1'b1);
    chki("t5_timeout_cycles", n, TO - 1);
    chk1("t5_err", out_err, 1'b1);
    chk8("t5_delta", out_delta, 8'h00);
    chk1("t5_wrap", out_wrap, 1'b0);
    cnt_in = 8'h30; out_ready = 1'b1; tick; out_ready = 1'b0;
    chk1("t5_ack", out_valid, 1'b0);
    repeat (4) tick;
    snap = 1'b1; tick; snap = 1'b0; tick;
    chk1("t5b_valid", out_valid, 1'b1);
    chk8("t5b_count", out_count, 8'h30);
    chk8("t5b_delta", out_delta, 8'h20);
    chk1("t5b_wrap", out_wrap, 1'b0);
    chk1("t5b_err", out_err, 1'b0);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    // Reset during SETTLE discards the pending capture.
    snap = 1'b1; tick; snap = 1'b0;
    chk1("t6_busy_settle", busy, 1'b1);
    #2 rst = 1'b0; #1;
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    tick; rst = 1'b1; tick;
    chk1("t6_post_valid", out_valid, 1'b0);
    chk1("t6_post_busy", busy, 1'b0);
    repeat (3) tick;
    snap = 1'b1; tick; snap = 1'b0; tick;
    chk1("t6_new_valid", out_valid, 1'b1);
    chk8("t6_new_delta", out_delta, 8'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
